rf_param_sb: RTL and testbench

RF_PARAM_SB -- requirements
Module: rf_param_sb

---
 rtl/rf_param_sb.sv | 130 +++++++++++++
 tb/tb_rf_param_sb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param_sb.sv
// Parameterised register file with a per-entry pending-write scoreboard and a
// sequential clear that walks every entry once.
module rf_param_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_busy_q, clr_busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic is_idle;
    logic eff_write;
    logic eff_rsv;

    assign is_idle = (state_q == StIdle);

    // A clear request in the same cycle takes priority and drops the write/reserve.
    assign eff_write = we && is_idle && !clr_req && !((ZERO_REG != 0) && (wa == '0));
    assign eff_rsv   = rsv_en && is_idle && !clr_req
                       && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_d = clr_busy_q;
        mem_d      = mem_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d    = StClear;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end else begin
                    if (eff_write) begin
                        mem_d[wa]  = wd;
                        busy_d[wa] = 1'b0;
                    end
                    // Applied after the write so a same-entry reserve stays set.
                    if (eff_rsv) begin
                        busy_d[rsv_addr] = 1'b1;
                    end
                end
            end
            StClear: begin
                mem_d[cnt_q]  = '0;
                busy_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d    = StIdle;
                    clr_busy_d = 1'b0;
                end
            end
            default: begin
                state_d    = StIdle;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            mem_q      <= '{default: '0};
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            mem_q      <= mem_d;
            busy_q     <= busy_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] ra);
        if (rst || ((ZERO_REG != 0) && (ra == '0))) begin
            return '0;
        end else if ((BYPASS != 0) && eff_write && (wa == ra)) begin
            return wd;
        end
        return mem_q[ra];
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
        if (rst || ((ZERO_REG != 0) && (ra == '0))) begin
            return 1'b0;
        end else if ((BYPASS != 0) && eff_write && (wa == ra)) begin
            return 1'b0;
        end
        return busy_q[ra];
    endfunction

    always_comb begin
        rd1   = read_data(ra1);
        rd2   = read_data(ra2);
        busy1 = read_busy(ra1);
        busy2 = read_busy(ra2);
    end

    assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_rf_param_sb.sv
// Bench for rf_param_sb: a default instance and a 64-bit/8-entry/no-zero-reg/no-bypass
// instance share stimulus and are checked every cycle against an abstract model.
module tb_rf_param_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, rsv_en = 1'b0, clr_req = 1'b0;
    logic [4:0]  wa = '0, ra1 = '0, ra2 = '0, rsv_addr = '0;
    logic [31:0] wd = '0;
    logic [63:0] wd_b;

    logic [31:0] rd1_a, rd2_a;
    logic [63:0] rd1_b, rd2_b;
    logic        busy1_a, busy2_a, clr_busy_a;
    logic        busy1_b, busy2_b, clr_busy_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    assign wd_b = {~wd, wd};

    always #5 clk = ~clk;

    rf_param_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_a), .rd2(rd2_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1_a), .busy2(busy2_a), .clr_req(clr_req), .clr_busy(clr_busy_a)
    );

    rf_param_sb #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa[2:0]), .wd(wd_b), .ra1(ra1[2:0]),
        .ra2(ra2[2:0]), .rd1(rd1_b), .rd2(rd2_b), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr[2:0]), .busy1(busy1_b), .busy2(busy2_b),
        .clr_req(clr_req), .clr_busy(clr_busy_b)
    );

    // Model: contents, pending flags, and cycles of clearing still to go.
    logic [63:0] md [2][32];
    bit          mb [2][32];
    int          left [2];

    function automatic int dep(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic bit zr(input int i);
        return (i == 0);
    endfunction

    function automatic bit bp(input int i);
        return (i == 0);
    endfunction

    function automatic int am(input int i, input logic [4:0] a);
        return int'(a) % dep(i);
    endfunction

    function automatic logic [63:0] wdi(input int i);
        return (i == 0) ? {32'h0, wd} : wd_b;
    endfunction

    function automatic bit ew(input int i);
        return (left[i] == 0) && !clr_req && we && !(zr(i) && am(i, wa) == 0);
    endfunction

    function automatic logic [63:0] exp_rd(input int i, input logic [4:0] ra);
        int a = am(i, ra);
        if (rst || (zr(i) && a == 0)) return 64'h0;
        if (bp(i) && ew(i) && am(i, wa) == a) return wdi(i);
        return md[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [4:0] ra);
        int a = am(i, ra);
        if (rst || (zr(i) && a == 0)) return 1'b0;
        if (bp(i) && ew(i) && am(i, wa) == a) return 1'b0;
        return mb[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0;
            for (int j = 0; j < 32; j++) begin
                md[i][j] = 64'h0;
                mb[i][j] = 1'b0;
            end
        end
    endtask

    task automatic model_tick();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (left[i] == 0) begin
                if (clr_req) begin
                    left[i] = dep(i);
                end else begin
                    if (ew(i)) begin
                        md[i][am(i, wa)] = wdi(i);
                        mb[i][am(i, wa)] = 1'b0;
                    end
                    if (rsv_en && !(zr(i) && am(i, rsv_addr) == 0))
                        mb[i][am(i, rsv_addr)] = 1'b1;
                end
            end else begin
                md[i][dep(i) - left[i]] = 64'h0;
                mb[i][dep(i) - left[i]] = 1'b0;
                left[i]--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_rd1", {32'h0, rd1_a}, exp_rd(0, ra1));
        chk("a_rd2", {32'h0, rd2_a}, exp_rd(0, ra2));
        chk("a_busy1", {63'h0, busy1_a}, {63'h0, exp_busy(0, ra1)});
        chk("a_busy2", {63'h0, busy2_a}, {63'h0, exp_busy(0, ra2)});
        chk("a_clr_busy", {63'h0, clr_busy_a}, {63'h0, (left[0] != 0)});
        chk("b_rd1", rd1_b, exp_rd(1, ra1));
        chk("b_rd2", rd2_b, exp_rd(1, ra2));
        chk("b_busy1", {63'h0, busy1_b}, {63'h0, exp_busy(1, ra1)});
        chk("b_busy2", {63'h0, busy2_b}, {63'h0, exp_busy(1, ra2)});
        chk("b_clr_busy", {63'h0, clr_busy_b}, {63'h0, (left[1] != 0)});
    endtask

    // Inputs are set by the caller; outputs checked mid-cycle, then the edge is taken.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic rv, input logic [4:0] radr, input logic cr);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        rsv_en = rv; rsv_addr = radr; clr_req = cr;
    endtask

    initial begin
        model_reset();
        // Reset held with a write pending: outputs must stay zero.
        set_in(1, 3, 32'hDEADBEEF, 3, 3, 1, 3, 0);
        step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        set_in(1, 3, 32'hDEADBEEF, 1, 2, 0, 0, 0);
        step();
        set_in(1, 0, 32'hCAFEF00D, 3, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 3, 0, 0, 0, 0);
        step();

        // Same-cycle forwarding on the default instance; old value on the other.
        set_in(1, 7, 32'h12345678, 3, 7, 0, 0, 0);
        step();
        set_in(0, 0, 0, 7, 7, 0, 0, 0);
        step();

        set_in(0, 0, 0, 5, 5, 1, 5, 0);
        step();
        set_in(1, 5, 32'h55AA55AA, 5, 5, 0, 0, 0);
        step();
        set_in(0, 0, 0, 5, 5, 0, 0, 0);
        step();
        set_in(1, 5, 32'h0BADCAFE, 5, 5, 1, 5, 0);
        step();
        set_in(0, 0, 0, 5, 5, 0, 0, 0);
        step();

        for (int n = 0; n < 300; n++) begin
            logic [4:0] a;
            a = 5'($urandom);
            set_in(1'($urandom), a, $urandom, ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
                   5'($urandom), 1'($urandom), 5'($urandom), ($urandom_range(0, 49) == 0));
            step();
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        while (left[0] != 0 || left[1] != 0) step();

        // Full sweep: fill, clear with a coincident write/reserve, hammer during it.
        for (int a = 0; a < 32; a++) begin
            set_in(1, 5'(a), $urandom, 5'(a), 5'($urandom), 1, 5'(a + 1), 0);
            step();
        end
        set_in(1, 9, 32'hFFFF0000, 9, 1, 1, 9, 1);
        step();
        for (int c = 0; c < 32; c++) begin
            set_in(1'($urandom), 5'($urandom), $urandom, 5'(c), 5'($urandom), 1'($urandom),
                   5'($urandom), (c < 5));
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a += 2) begin
            ra1 = 5'(a);
            ra2 = 5'(a + 1);
            step();
        end

        // Fill again and reset ten cycles into the sweep.
        for (int a = 0; a < 32; a++) begin
            set_in(1, 5'(a), $urandom, 5'(a), 5'(a), 1, 5'(a), 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ra1 = 5'($urandom);
            ra2 = 5'($urandom);
            step();
        end
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
        set_in(1, 12, 32'hA5A5_1234, 12, 20, 0, 0, 0);
        step();
        set_in(0, 0, 0, 12, 20, 0, 0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
